// File: rtl/aes_inv_cipher.sv
// aes_inv_cipher
// Iterative AES inverse cipher (FIPS-197 decryption). It runs one round per clock
// and pulls round keys from an external key-schedule store, asking for them in
// descending order (Nr..0) over a req/valid handshake. AES-128/192/256 are
// selected with Nk (4/6/8).
//
// Byte order: bits [127:120] hold state byte 0 (row 0, col 0), column-major.
// This holds for ct, rk and pt.
//
// Ports
//   clk       clock
//   rst_n     asynchronous active-low reset
//   start     accept a new ciphertext when idle
//   clear     synchronous abort back to IDLE (wins over start)
//   ct        ciphertext, sampled on an accepted start
//   busy      high while a block is in progress
//   rk_req    round key request
//   rk_idx    index of the requested round key
//   rk        round key for rk_idx, sampled only in the handshake cycle
//   rk_valid  rk valid; consumed when rk_req && rk_valid
//   pt        plaintext result, held until the next completed block
//   valid     one-cycle pulse when pt is updated
module aes_inv_cipher #(
    parameter int Nk = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear,
    input  logic [127:0] ct,
    output logic         busy,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    input  logic         rk_valid,
    output logic [127:0] pt,
    output logic         valid
);
    localparam int Nr = Nk + 6;
    localparam logic [3:0] NR_IDX = 4'(Nr);

    if (Nk != 4 && Nk != 6 && Nk != 8) begin : g_badNk
        $error("aes_inv_cipher: Nk must be 4, 6 or 8");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    state_t       r_state;
    state_t       w_nextState;
    logic [127:0] r_data;
    logic [3:0]   r_rnd;
    logic [127:0] r_pt;
    logic [127:0] w_isr;
    logic [127:0] w_isb;
    logic [127:0] w_ark;
    logic [127:0] w_imc;
    logic [127:0] w_roundOut;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254 (square-and-multiply); maps 0 to 0,
    // which is exactly what the S-box construction needs.
    function automatic logic [7:0] gInv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    // Inverse S-box derived arithmetically: undo the affine map, then invert.
    // This avoids a hand-typed 256-entry table that could hide a typo.
    function automatic logic [7:0] invSbox(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gInv(b);
    endfunction

    // Row r rotates right by r: output column c takes input column c-r.
    function automatic logic [127:0] invShiftRows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] invSubBytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) begin
            o[127 - 8*i -: 8] = invSbox(s[127 - 8*i -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] invMixColumns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
            o[119 - 32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
            o[111 - 32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
            o[103 - 32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
        end
        return o;
    endfunction

    assign w_isr = invShiftRows(r_data);
    assign w_isb = invSubBytes(w_isr);
    assign w_ark = w_isb ^ rk;
    assign w_imc = invMixColumns(w_ark);

    // The first key is a plain AddRoundKey, the last key skips InvMixColumns.
    always_comb begin
        w_roundOut = w_imc;
        if (r_rnd == NR_IDX)     w_roundOut = r_data ^ rk;
        else if (r_rnd == 4'd0)  w_roundOut = w_ark;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        rk_req      = 1'b0;
        rk_idx      = 4'd0;
        valid       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !clear) w_nextState = ROUND;
            end
            ROUND: begin
                busy   = 1'b1;
                rk_req = 1'b1;
                rk_idx = r_rnd;
                if (clear)                          w_nextState = IDLE;
                else if (rk_valid && r_rnd == 4'd0) w_nextState = DONE;
            end
            DONE: begin
                valid       = 1'b1;
                w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // pt is loaded on the final handshake so that it is already updated in
    // the DONE cycle, where valid pulses. The counter stops at 0 so rk_idx
    // never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_rnd  <= 4'd0;
            r_pt   <= '0;
        end else if (!clear) begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_data <= ct;
                        r_rnd  <= NR_IDX;
                    end
                end
                ROUND: begin
                    if (rk_valid) begin
                        r_data <= w_roundOut;
                        if (r_rnd == 4'd0) r_pt  <= w_ark;
                        else               r_rnd <= r_rnd - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pt = r_pt;

endmodule
